// File: rtl/mem_resp_pkg.sv
// ============================================================================
// mem_resp_pkg : shared FSM states and address helpers for mem_responder
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int WORD_BYTES = 4;

    function automatic logic [63:0] addr_to_index(input logic [63:0] addr);
        return addr / 64'(WORD_BYTES);
    endfunction

    // A usable address is word-aligned and lands inside the backing array.
    function automatic logic addr_is_valid(input logic [63:0] addr, input int unsigned depth);
        return ((addr % 64'(WORD_BYTES)) == 64'd0) && (addr_to_index(addr) < 64'(depth));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_array.sv
// ============================================================================
// mem_resp_array : single-port word array, synchronous write, registered read
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_resp_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Read data holds its value whenever re_i is low.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : one-outstanding-request memory responder with fixed wait
//                 latency. Optional counters: define MEM_RESPONDER_STATS_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_errs
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rd_ok_q;
    logic             we_q;
    logic             bad_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;

    logic [IDX_W-1:0] idx_d;
    logic             bad_d;
    logic             arr_we;
    logic             arr_re;
    logic [31:0]      arr_rdata;

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] stat_reads_q;
    logic [31:0] stat_writes_q;
    logic [31:0] stat_errs_q;
`endif

    assign idx_d = req_addr[IDX_W+1:2];
    assign bad_d = !addr_is_valid(64'(req_addr), unsigned'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
`ifdef MEM_RESPONDER_STATS_EN
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_errs_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        bad_q       <= bad_d;
                        idx_q       <= idx_d;
                        wdata_q     <= req_wdata;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACCESS: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= bad_q;
                    rd_ok_q     <= !we_q && !bad_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_ok_q     <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
`ifdef MEM_RESPONDER_STATS_EN
                        if (bad_q) begin
                            stat_errs_q <= stat_errs_q + 32'd1;
                        end else if (we_q) begin
                            stat_writes_q <= stat_writes_q + 32'd1;
                        end else begin
                            stat_reads_q <= stat_reads_q + 32'd1;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only ACCESS touches the array, so a reset during WAIT drops the write.
    assign arr_we = (state_q == ACCESS) && we_q && !bad_q;
    assign arr_re = (state_q == ACCESS) && !we_q && !bad_q;

    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rd_ok_q ? arr_rdata : 32'd0;

`ifdef MEM_RESPONDER_STATS_EN
    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

`default_nettype wire
